error_reporter: RTL and testbench

Collects error events from NUM_SRC independent producers, arbitrates them round-robin, and buffers them in a FIFO. Drains the FIFO as single-entry writes onto the write port of the error RAM: write_enable, write_address and write_error. Sits between the detecting logic and the error RAM, and is the write-side counterpart of the RAM's lookup-by-address read port. Filters out entries the RAM cannot represent (address 0, error code 0).

---
 rtl/err_report_pkg.sv | 20 ++
 rtl/err_report_fifo.sv | 89 ++++++++
 rtl/error_reporter.sv | 172 +++++++++++++++++
 tb/tb_error_reporter.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/err_report_pkg.sv
// err_report_pkg
//   Shared types for the error reporter: field widths of an error-RAM entry,
//   the packed {address, error} entry carried through the FIFO, and the
//   output FSM state encoding.
package err_report_pkg;

    localparam int ADDR_W = 32;
    localparam int ERR_W  = 10;

    typedef struct packed {
        logic [ADDR_W-1:0] address;
        logic [ERR_W-1:0]  error;
    } err_entry_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage

// File: rtl/err_report_fifo.sv
// err_report_fifo
//   Synchronous FIFO of err_entry_t with a first-word-fall-through head.
//   Ports:
//     clk, rst        clock, synchronous active-high reset
//     push, push_data write an entry (ignored when full)
//     pop, head_data  head entry (valid when !empty); pop advances it
//     newest_address  address of the most recently pushed entry
//     newest_wr,      overwrite the error code of the newest entry in place
//     newest_error      (ignored when a push happens in the same cycle)
//     full, empty, count  occupancy, all from registered state
module err_report_fifo
    import err_report_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  err_entry_t               push_data,
    input  logic                     pop,
    output err_entry_t               head_data,
    output logic [ADDR_W-1:0]        newest_address,
    input  logic                     newest_wr,
    input  logic [ERR_W-1:0]         newest_error,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    err_entry_t       mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0] newest_ptr;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok, pop_ok;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign count   = count_q;

    // DEPTH is a power of two, so pointer wrap is plain overflow.
    assign newest_ptr     = wr_ptr_q - 1'b1;
    assign head_data      = mem[rd_ptr_q];
    assign newest_address = mem[newest_ptr].address;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is not reset; the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr_q] <= push_data;
        end else if (newest_wr && !empty) begin
            mem[newest_ptr].error <= newest_error;
        end
    end

endmodule

// File: rtl/error_reporter.sv
// error_reporter
//   Round-robin collector of error events from NUM_SRC producers, buffered in
//   a FIFO and drained one entry per handshake onto the error RAM write port.
//   Entries with address 0 or error code 0 are consumed and counted, never
//   written.
//   Ports:
//     clk, rst                          clock, synchronous active-high reset
//     src_valid/src_address/src_error   per-source event request (packed)
//     src_ready                         one-hot grant, combinational
//     write_enable/address/error        error RAM write request
//     write_ready                       RAM accept
//     pending                           FIFO occupancy
//     drop_count                        saturating count of filtered entries
//     busy                              pending != 0 or write_enable
//   Build option: ERR_REPORT_COALESCE_EN merges a new event into the newest
//   queued entry when their addresses match (newest error code wins).
module error_reporter
    import err_report_pkg::*;
#(
    parameter int NUM_SRC    = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_SRC-1:0]            src_valid,
    input  logic [NUM_SRC*ADDR_W-1:0]     src_address,
    input  logic [NUM_SRC*ERR_W-1:0]      src_error,
    output logic [NUM_SRC-1:0]            src_ready,
    output logic                          write_enable,
    output logic [ADDR_W-1:0]             write_address,
    output logic [ERR_W-1:0]              write_error,
    input  logic                          write_ready,
    output logic [$clog2(FIFO_DEPTH):0]   pending,
    output logic [15:0]                   drop_count,
    output logic                          busy
);

    localparam int RR_W  = $clog2(NUM_SRC);
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

`ifdef ERR_REPORT_COALESCE_EN
    localparam bit COALESCE_EN = 1'b1;
`else
    localparam bit COALESCE_EN = 1'b0;
`endif

    err_entry_t        src_entry [NUM_SRC];
    logic [RR_W-1:0]   rr_q, rr_d;
    logic [RR_W-1:0]   grant_idx;
    logic              grant_found;
    logic              xfer;
    err_entry_t        sel_entry;
    logic              entry_ok;
    logic              coalesce_hit, do_coalesce;
    logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
    err_entry_t        fifo_head;
    logic [ADDR_W-1:0] newest_address;
    logic [CNT_W-1:0]  fifo_count;
    logic [15:0]       drop_q, drop_d;
    state_t            state_q, state_d;
    err_entry_t        out_q, out_d;

    for (genvar gi = 0; gi < NUM_SRC; gi++) begin : g_src
        assign src_entry[gi] = {src_address[gi*ADDR_W +: ADDR_W], src_error[gi*ERR_W +: ERR_W]};
        assign src_ready[gi] = grant_found && !fifo_full && (grant_idx == RR_W'(gi));
    end

    // First valid source at or after rr, searched modulo NUM_SRC.
    always_comb begin
        logic [RR_W:0] cand;
        grant_found = 1'b0;
        grant_idx   = '0;
        cand        = '0;
        for (int k = 0; k < NUM_SRC; k++) begin
            cand = {1'b0, rr_q} + (RR_W+1)'(k);
            if (cand >= (RR_W+1)'(NUM_SRC)) begin
                cand = cand - (RR_W+1)'(NUM_SRC);
            end
            if (!grant_found && src_valid[cand[RR_W-1:0]]) begin
                grant_found = 1'b1;
                grant_idx   = cand[RR_W-1:0];
            end
        end
    end

    assign xfer      = grant_found && !fifo_full;
    assign sel_entry = src_entry[grant_idx];
    assign entry_ok  = (sel_entry.address != '0) && (sel_entry.error != '0);

    // The newest entry can only be the one leaving when it is also the head.
    assign coalesce_hit = !fifo_empty && (newest_address == sel_entry.address)
                          && !(fifo_pop && fifo_count == CNT_W'(1));
    assign do_coalesce  = COALESCE_EN && xfer && entry_ok && coalesce_hit;
    assign fifo_push    = xfer && entry_ok && !do_coalesce;

    always_comb begin
        rr_d   = rr_q;
        drop_d = drop_q;
        if (xfer) begin
            rr_d = (grant_idx == RR_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
            if (!entry_ok && drop_q != 16'hFFFF) begin
                drop_d = drop_q + 16'd1;
            end
        end
    end

    err_report_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk            (clk),
        .rst            (rst),
        .push           (fifo_push),
        .push_data      (sel_entry),
        .pop            (fifo_pop),
        .head_data      (fifo_head),
        .newest_address (newest_address),
        .newest_wr      (do_coalesce),
        .newest_error   (sel_entry.error),
        .full           (fifo_full),
        .empty          (fifo_empty),
        .count          (fifo_count)
    );

    // Output FSM: the output registers load only when an entry is popped.
    always_comb begin
        state_d  = state_q;
        out_d    = out_q;
        fifo_pop = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    out_d    = fifo_head;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                if (write_ready) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        out_d    = fifo_head;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            out_q   <= '0;
            rr_q    <= '0;
            drop_q  <= '0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rr_q    <= rr_d;
            drop_q  <= drop_d;
        end
    end

    assign write_enable  = (state_q == ISSUE);
    assign write_address = out_q.address;
    assign write_error   = out_q.error;
    assign pending       = fifo_count;
    assign drop_count    = drop_q;
    assign busy          = (fifo_count != '0) || write_enable;

endmodule

// File: tb/tb_error_reporter.sv
// tb_error_reporter
//   Bench for error_reporter: a queue-based reference model advanced every
//   clock, a per-cycle compare process, directed scenarios with literal
//   expectations, and a randomized phase.
module tb_error_reporter;

    localparam int N     = 4;
    localparam int DEPTH = 8;
`ifdef ERR_REPORT_COALESCE_EN
    localparam bit COAL = 1'b1;
`else
    localparam bit COAL = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] a;
        logic [9:0]  e;
    } ent_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [N-1:0]      src_valid = '0;
    logic [N*32-1:0]   src_address = '0;
    logic [N*10-1:0]   src_error = '0;
    logic [N-1:0]      src_ready;
    logic              write_enable;
    logic [31:0]       write_address;
    logic [9:0]        write_error;
    logic              write_ready = 1'b0;
    logic [3:0]        pending;
    logic [15:0]       drop_count;
    logic              busy;

    error_reporter #(.NUM_SRC(N), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .src_valid(src_valid), .src_address(src_address),
        .src_error(src_error), .src_ready(src_ready), .write_enable(write_enable),
        .write_address(write_address), .write_error(write_error),
        .write_ready(write_ready), .pending(pending), .drop_count(drop_count),
        .busy(busy)
    );

    always #5 clk = ~clk;

    int   total = 0;
    int   bad   = 0;
    bit   chk_en = 1'b0;
    ent_t dut_w[$];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            if (bad <= 40)
                $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    ent_t mq[$];
    int   m_rr;
    bit   m_out_v;
    ent_t m_out;
    int   m_drop;

    function automatic ent_t src_ent(input int i);
        ent_t t;
        t.a = src_address[i*32 +: 32];
        t.e = src_error[i*10 +: 10];
        return t;
    endfunction

    // Index of the source granted this cycle, or -1.
    function automatic int m_grant();
        if (mq.size() >= DEPTH) return -1;
        for (int k = 0; k < N; k++) begin
            if (src_valid[(m_rr + k) % N]) return (m_rr + k) % N;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            mq.delete();
            m_rr = 0; m_out_v = 1'b0; m_out = '0; m_drop = 0;
        end else begin
            int   g;
            int   pre;
            bit   popped;
            ent_t in;
            g = m_grant();
            pre = mq.size();
            popped = 1'b0;
            if (!m_out_v) begin
                if (pre > 0) begin m_out = mq.pop_front(); m_out_v = 1'b1; popped = 1'b1; end
            end else if (write_ready) begin
                if (pre > 0) begin m_out = mq.pop_front(); popped = 1'b1; end
                else m_out_v = 1'b0;
            end
            if (g >= 0) begin
                in = src_ent(g);
                m_rr = (g + 1) % N;
                if (in.a == 0 || in.e == 0) begin
                    if (m_drop < 65535) m_drop++;
                end else if (COAL && pre > 0 && !(popped && pre == 1) && mq[mq.size()-1].a == in.a) begin
                    mq[mq.size()-1].e = in.e;
                end else begin
                    mq.push_back(in);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        if (chk_en) begin
            logic [N-1:0] er;
            int g;
            er = '0;
            g = m_grant();
            if (g >= 0) er[g] = 1'b1;
            chk("cyc_src_ready", 64'(src_ready), 64'(er));
            chk("cyc_write_enable", 64'(write_enable), 64'(m_out_v));
            chk("cyc_write_address", 64'(write_address), 64'(m_out.a));
            chk("cyc_write_error", 64'(write_error), 64'(m_out.e));
            chk("cyc_pending", 64'(pending), 64'(mq.size()));
            chk("cyc_drop_count", 64'(drop_count), 64'(m_drop));
            chk("cyc_busy", 64'(busy), 64'(mq.size() != 0 || m_out_v));
            if (write_enable && write_ready) dut_w.push_back({write_address, write_error});
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_src(input int i, input bit v, input logic [31:0] a, input logic [9:0] e);
        src_valid[i] = v;
        src_address[i*32 +: 32] = a;
        src_error[i*10 +: 10] = e;
    endtask

    task automatic do_reset();
        src_valid = '0;
        rst = 1'b1;
        step();
        chk_en = 1'b1;
        step();
        rst = 1'b0;
        dut_w.delete();
    endtask

    task automatic wait_idle(input int max_cyc, input string nm);
        int n;
        n = 0;
        while (busy && n < max_cyc) begin step(); n++; end
        chk(nm, 64'(busy), 64'(0));
    endtask

    task automatic cmp_writes(input string nm, input ent_t exp[$]);
        chk({nm, "_count"}, 64'(dut_w.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < dut_w.size(); i++)
            chk(nm, 64'(dut_w[i]), 64'(exp[i]));
    endtask

    // ---------------- directed + random scenarios ----------------
    initial begin
        ent_t exp_w[$];
        ent_t ev[10];
        int   idx;
        int   gcnt[N];

        do_reset();
        chk("reset_write_enable", 64'(write_enable), 64'(0));
        chk("reset_write_address", 64'(write_address), 64'(0));
        chk("reset_write_error", 64'(write_error), 64'(0));
        chk("reset_pending", 64'(pending), 64'(0));
        chk("reset_drop_count", 64'(drop_count), 64'(0));
        chk("reset_busy", 64'(busy), 64'(0));
        chk("reset_src_ready", 64'(src_ready), 64'(0));

        // Single event from source 2: cycle 0 accept, cycle 2 write.
        write_ready = 1'b1;
        set_src(2, 1'b1, 32'h0000_1000, 10'h005);
        #1 chk("single_grant", 64'(src_ready), 64'h4);
        step();
        set_src(2, 1'b0, 32'h0, 10'h0);
        chk("single_pending_c1", 64'(pending), 64'd1);
        chk("single_we_c1", 64'(write_enable), 64'd0);
        step();
        chk("single_we_c2", 64'(write_enable), 64'd1);
        chk("single_addr_c2", 64'(write_address), 64'h1000);
        chk("single_err_c2", 64'(write_error), 64'h5);
        step();
        step();
        chk("single_busy_c4", 64'(busy), 64'd0);

        // Fairness: all sources valid, grants rotate 0,1,2,3,...
        do_reset();
        write_ready = 1'b1;
        for (int s = 0; s < N; s++) gcnt[s] = 0;
        for (int i = 0; i < 16; i++) begin
            for (int s = 0; s < N; s++) set_src(s, 1'b1, 32'h100 + 32'(i*4 + s), 10'(s + 1));
            #1;
            chk("fair_grant", 64'(src_ready), 64'(1 << (i % 4)));
            for (int s = 0; s < N; s++) if (src_ready[s]) gcnt[s]++;
            step();
        end
        src_valid = '0;
        for (int s = 0; s < N; s++) chk("fair_count", 64'(gcnt[s]), 64'd4);
        wait_idle(40, "fair_drain");

        // Backpressure: one entry sits in the output register, eight fill the FIFO.
        do_reset();
        write_ready = 1'b0;
        for (int i = 0; i < 10; i++) ev[i] = {32'h5000 + 32'(i*16), 10'(i + 1)};
        idx = 0;
        for (int c = 0; c < 14; c++) begin
            set_src(0, 1'b1, ev[idx].a, ev[idx].e);
            #1;
            if (src_ready[0] && idx < 9) idx++;
            step();
        end
        chk("bp_accepted", 64'(idx), 64'(DEPTH + 1));
        chk("bp_pending", 64'(pending), 64'(DEPTH));
        chk("bp_src_ready", 64'(src_ready), 64'(0));
        src_valid = '0;
        write_ready = 1'b1;
        wait_idle(40, "bp_drain");
        exp_w.delete();
        for (int i = 0; i < 9; i++) exp_w.push_back(ev[i]);
        cmp_writes("bp_order", exp_w);

        // Filtering.
        do_reset();
        write_ready = 1'b1;
        set_src(0, 1'b1, 32'h0, 10'h3);
        step();
        set_src(0, 1'b1, 32'h2000, 10'h0);
        step();
        src_valid = '0;
        step(); step(); step();
        chk("filter_drop", 64'(drop_count), 64'd2);
        chk("filter_pending", 64'(pending), 64'd0);
        chk("filter_writes", 64'(dut_w.size()), 64'd0);

        // Saturation of drop_count.
        set_src(1, 1'b1, 32'h0, 10'h7);
        for (int i = 0; i < 65540; i++) step();
        src_valid = '0;
        step();
        chk("drop_saturate", 64'(drop_count), 64'hFFFF);

        // Reset while draining.
        do_reset();
        write_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            set_src(2, 1'b1, 32'h7000 + 32'(i), 10'h1 + 10'(i));
            step();
        end
        src_valid = '0;
        step();
        chk("mid_pending", 64'(pending), 64'd5);
        chk("mid_we", 64'(write_enable), 64'd1);
        rst = 1'b1;
        step();
        chk("mid_rst_we", 64'(write_enable), 64'd0);
        chk("mid_rst_pending", 64'(pending), 64'd0);
        set_src(1, 1'b1, 32'h11, 10'h1);
        set_src(3, 1'b1, 32'h33, 10'h1);
        #1 chk("mid_rst_rr", 64'(src_ready), 64'h2);
        src_valid = '0;
        step();
        rst = 1'b0;
        write_ready = 1'b1;
        dut_w.delete();
        for (int i = 0; i < 5; i++) step();
        chk("mid_no_writes", 64'(dut_w.size()), 64'd0);

        // Coalescing: the first 0x3000 entry is still queued behind 0x4000.
        do_reset();
        write_ready = 1'b0;
        set_src(0, 1'b1, 32'h4000, 10'h2);
        step();
        src_valid = '0;
        step(); step();
        set_src(0, 1'b1, 32'h3000, 10'h1);
        step();
        set_src(0, 1'b1, 32'h3000, 10'h7);
        step();
        src_valid = '0;
        step();
        chk("coal_pending", 64'(pending), COAL ? 64'd1 : 64'd2);
        write_ready = 1'b1;
        wait_idle(20, "coal_drain");
        exp_w.delete();
        exp_w.push_back({32'h4000, 10'h2});
        if (!COAL) exp_w.push_back({32'h3000, 10'h1});
        exp_w.push_back({32'h3000, 10'h7});
        cmp_writes("coal_writes", exp_w);

        // Randomized traffic against the model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            for (int s = 0; s < N; s++)
                set_src(s, 1'($urandom_range(0, 1)), 32'($urandom_range(0, 3) * 16),
                        10'($urandom_range(0, 3)));
            write_ready = ($urandom_range(0, 3) != 0);
            step();
        end
        src_valid = '0;
        write_ready = 1'b1;
        wait_idle(40, "rand_drain");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
